// File: rtl/subtractor_serial.sv
// -----------------------------------------------------------------------------
// subtractor_serial
//
// Bit-serial ripple-borrow subtractor. It computes diff = a - b - bin, one bit
// per clock and LSB first, through a single shared full-subtractor cell. A
// start/busy/done handshake lets a sequencer issue operations back to back.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   request; accepted only in IDLE or DONE
//   a         in   [WIDTH-1:0] minuend, captured on an accepted start
//   b         in   [WIDTH-1:0] subtrahend, captured on an accepted start
//   bin       in   borrow-in, captured on an accepted start
//   busy      out  high while the operation is running
//   done      out  one-cycle pulse: diff/bout/overflow hold a new result
//   diff      out  [WIDTH-1:0] a - b - bin modulo 2^WIDTH
//   bout      out  borrow-out, 1 iff a < b + bin (unsigned)
//   overflow  out  two's-complement overflow of a - b - bin
//
// Timing: a start accepted at edge k gives done high in the cycle after edge
// k+WIDTH. The result outputs change only at that final edge, so a partial
// result is never visible.
// -----------------------------------------------------------------------------
module subtractor_serial #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  // Just wide enough to count 0..WIDTH-1 without wrapping early.
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;

  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             br;
  logic [CW-1:0]    cnt;
  // Holds the WIDTH-1 bits already produced. The last bit goes straight into
  // diff, which is why this register is one bit shorter than the result.
  logic [WIDTH-2:0] sh;

  logic             accept;
  logic             last;
  logic             a_bit;
  logic             b_bit;
  logic             d_bit;
  logic             br_nxt;
  logic [WIDTH-1:0] res_nxt;

  // ---------------------------------------------------------------------------
  // Full-subtractor cell working on the bit that cnt selects
  // ---------------------------------------------------------------------------
  assign a_bit   = a_r[cnt];
  assign b_bit   = b_r[cnt];
  assign d_bit   = a_bit ^ b_bit ^ br;
  assign br_nxt  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br);
  // New bit enters at the MSB, so after WIDTH steps bit 0 sits at the LSB.
  assign res_nxt = {d_bit, sh};
  assign last    = (state == RUN) && (cnt == CW'(WIDTH - 1));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples its inputs as they were before the edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    accept    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        // start is ignored here; the in-flight operation is not disturbed.
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          // Back-to-back accept, no idle bubble.
          accept    = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: operand capture, serial step, result load
  // ---------------------------------------------------------------------------
  // NOTE: these are plain registers, not a memory array, so all of them are
  // cleared by reset; an abort leaves no stale operands or result behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r      <= '0;
      b_r      <= '0;
      br       <= 1'b0;
      cnt      <= '0;
      sh       <= '0;
      diff     <= '0;
      bout     <= 1'b0;
      overflow <= 1'b0;
    end else if (accept) begin
      a_r <= a;
      b_r <= b;
      br  <= bin;
      cnt <= '0;
      sh  <= '0;
    end else if (state == RUN) begin
      sh  <= res_nxt[WIDTH-1:1];
      br  <= br_nxt;
      cnt <= cnt + CW'(1);
      if (last) begin
        diff     <= res_nxt;
        bout     <= br_nxt;
        // Operands of differing sign whose result takes the sign of b.
        overflow <= (a_r[WIDTH-1] ^ b_r[WIDTH-1]) & (d_bit ^ a_r[WIDTH-1]);
      end
    end
  end

endmodule

// File: tb/tb_subtractor_serial.sv
// -----------------------------------------------------------------------------
// tb_subtractor_serial
//
// Self-checking bench for subtractor_serial with WIDTH=4. It runs directed
// vectors with hand-computed results, handshake corner cases, reset during an
// operation, and a sweep of every a, b and bin against a behavioural
// subtraction.
// -----------------------------------------------------------------------------
module tb_subtractor_serial;

  localparam int WIDTH = 4;
  localparam int LAT   = 4;
  localparam int BOUND = 20;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             overflow;

  int n_cmp;
  int n_err;

  subtractor_serial #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .bin      (bin),
    .busy     (busy),
    .done     (done),
    .diff     (diff),
    .bout     (bout),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present an operation on a falling edge, let the next rising edge accept
  // it, and drop start on the falling edge after that.
  task automatic issue(input logic [3:0] ta, input logic [3:0] tb_v, input logic tbin);
    @(negedge clk);
    a     = ta;
    b     = tb_v;
    bin   = tbin;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Called on the falling edge right after the accepting rising edge.
  // Returns the number of falling edges until done is seen (0 on timeout).
  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= BOUND; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("done_timeout", 32'(done), 32'd1);
  endtask

  // Full operation with result checks against hand-computed values.
  task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                        input logic tbin, input logic [3:0] e_diff, input logic e_bout,
                        input logic e_ovf, input bit chk_lat);
    int lat;
    issue(ta, tb_v, tbin);
    wait_done(lat);
    if (chk_lat) check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_diff"}, 32'(diff), 32'(e_diff));
    check({tag, "_bout"}, 32'(bout), 32'(e_bout));
    check({tag, "_ovf"},  32'(overflow), 32'(e_ovf));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd0);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_diff"}, 32'(diff), 32'd0);
    check({tag, "_bout"}, 32'(bout), 32'd0);
    check({tag, "_ovf"},  32'(overflow), 32'd0);
  endtask

  logic [4:0] full;
  logic [3:0] m_diff;
  logic       m_bout;
  logic       m_ovf;
  int         lat;
  bit         saw_done;

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("por");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle");

    // Basic, borrow and signed-overflow vectors.
    run_op("sub_7_3",   4'd7, 4'd3,  1'b0, 4'd4,  1'b0, 1'b0, 1'b1);
    run_op("sub_5_5",   4'd5, 4'd5,  1'b0, 4'd0,  1'b0, 1'b0, 1'b1);
    run_op("sub_3_5",   4'd3, 4'd5,  1'b0, 4'd14, 1'b1, 1'b0, 1'b1);
    run_op("sub_0_0_b", 4'd0, 4'd0,  1'b1, 4'd15, 1'b1, 1'b0, 1'b1);
    run_op("sub_8_1",   4'd8, 4'd1,  1'b0, 4'd7,  1'b0, 1'b1, 1'b1);
    run_op("sub_7_15",  4'd7, 4'd15, 1'b0, 4'd8,  1'b1, 1'b1, 1'b1);

    // start during RUN is ignored; start in DONE is accepted back to back.
    issue(4'd9, 4'd2, 1'b0);
    @(negedge clk);
    a = 4'd1; b = 4'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hs_busy_run", 32'(busy), 32'd1);
    @(negedge clk);
    @(negedge clk);
    check("hs_done_first", 32'(done), 32'd1);
    check("hs_diff_first", 32'(diff), 32'd7);
    a = 4'd6; b = 4'd4; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("hs_b2b_busy", 32'(busy), 32'd1);
    check("hs_b2b_done", 32'(done), 32'd0);
    check("hs_diff_hold", 32'(diff), 32'd7);
    wait_done(lat);
    check("hs_b2b_latency", 32'(lat), 32'(LAT));
    check("hs_diff_second", 32'(diff), 32'd2);
    @(negedge clk);

    // Reset during RUN: outputs clear asynchronously and no done appears.
    issue(4'd12, 4'd3, 1'b0);
    @(negedge clk);
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst_async");
    saw_done = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    rst_n = 1'b1;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) saw_done = 1'b1;
    end
    check("rst_no_done", 32'(saw_done), 32'd0);
    check_reset_outputs("rst_after");
    run_op("post_rst_12_3", 4'd12, 4'd3, 1'b0, 4'd9, 1'b0, 1'b0, 1'b1);

    // Exhaustive sweep against a behavioural subtraction.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          full   = 5'(ia) - 5'(ib) - 5'(ic);
          m_diff = full[3:0];
          m_bout = (ia < ib + ic);
          m_ovf  = (4'(ia) >> 3 != 4'(ib) >> 3) && (m_diff[3] != 1'(ia >> 3));
          issue(4'(ia), 4'(ib), 1'(ic));
          wait_done(lat);
          check($sformatf("sweep_diff_%0d_%0d_%0d", ia, ib, ic), 32'(diff), 32'(m_diff));
          check($sformatf("sweep_bout_%0d_%0d_%0d", ia, ib, ic), 32'(bout), 32'(m_bout));
          check($sformatf("sweep_ovf_%0d_%0d_%0d",  ia, ib, ic), 32'(overflow), 32'(m_ovf));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/subtractor_serial.md
Name: subtractor_serial

Overview:
- Multi-cycle bit-serial ripple-borrow subtractor: computes diff = a - b - bin, one bit per clock, LSB first.
- Inverse-direction companion to the combinational ripple-carry adder. Trades latency for one shared full-subtractor cell.
- Start/busy/done handshake, so a controlling FSM or datapath sequencer can issue operations.

Parameters:
WIDTH, 4, operand/result width in bits (>= 2)

Ports:
clk  input  1  system clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising edge, accepted only in IDLE or DONE
a  input  WIDTH  minuend; captured on accepted start
b  input  WIDTH  subtrahend; captured on accepted start
bin  input  1  borrow-in; captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse: result valid
diff  output  WIDTH  a - b - bin modulo 2^WIDTH
bout  output  1  borrow-out; 1 iff a < b + bin (unsigned)
overflow  output  1  two's-complement overflow of a - b - bin

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE.
  - busy=0, done=0, diff=0, bout=0, overflow=0.
  - Internal operand registers, borrow register and bit counter are cleared.
- FSM states IDLE, RUN, DONE:
  - IDLE: on start=1 at an edge, latch a, b and bin. Clear the bit counter and the internal shift-result register. Go to RUN.
  - RUN: busy=1. At each edge, process bit i = counter:
    - d_i = a_i ^ b_i ^ br
    - br_next = (~a_i & b_i) | (~(a_i ^ b_i) & br)
    - br starts at the latched bin.
    - d_i is written into the result shift register and the counter is incremented.
    - At the edge processing bit WIDTH-1, load diff/bout/overflow output registers and go to DONE.
  - DONE: done=1 for exactly this cycle, busy=0.
    - With start=1 at the next edge: behave as IDLE accept (back-to-back, no bubble).
    - Otherwise go to IDLE.
- Latency: start accepted at edge k; done high in the cycle following edge k+WIDTH. For WIDTH=4, done is seen 4 cycles after the start edge.
- Throughput: one result per WIDTH+1 cycles minimum.
- start while in RUN is ignored: no re-latch and no effect on the in-flight operation.
- Operand inputs are don't-care except at an accepted start edge.
- diff, bout and overflow update only at the final RUN edge. They hold their values through DONE, IDLE and the next RUN until the next completion. No partial results are ever visible on diff.
- bout = final borrow (br after bit WIDTH-1).
- overflow = (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), using the latched operands. bin does not enter this formula separately; it is reflected through diff.
- Width rules: all arithmetic is modulo 2^WIDTH. The counter is ceil(log2(WIDTH)) bits and must not wrap before reaching WIDTH-1.
- Reset mid-operation: the operation is aborted, all outputs return to reset values, and there is no done pulse.
- done and busy are never both high.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles mid-traffic -> busy=0, done=0, diff=0, bout=0, overflow=0 immediately (async), and they remain 0 with start=0.
- Basic cases, WIDTH=4, one start each:
  - a=7, b=3, bin=0 -> done exactly 4 cycles after the start edge; diff=4, bout=0, overflow=0.
  - a=5, b=5, bin=0 -> diff=0, bout=0, overflow=0.
- Borrow cases:
  - a=3, b=5, bin=0 -> diff=14, bout=1, overflow=0.
  - a=0, b=0, bin=1 -> diff=15, bout=1, overflow=0.
- Signed overflow: a=8, b=1, bin=0 -> diff=7, bout=0, overflow=1. Also a=7, b=15, bin=0 -> diff=8, bout=1, overflow=1.
- Handshake:
  - Start a=9, b=2. Pulse start with a=1, b=1 two cycles later (during RUN) -> ignored; result diff=7.
  - Assert start in the DONE cycle with a=6, b=4 -> busy next cycle, diff=2 after 4 more cycles.
  - diff holds 7 until then.
- Reset mid-run: start a=12, b=3, then drop rst_n after 2 RUN cycles -> no done pulse, outputs 0. A fresh start after release returns correct results.
- Exhaustive sweep: all a, b in 0..15 and bin in 0..1 against a reference model -> diff/bout/overflow match on every done.
